video_timing_gen: RTL and testbench

//  Pixel-clock video timing and test-pattern source that feeds the three TMDS encode lanes.

---
 rtl/video_timing_gen_pkg.sv | 53 +++++
 rtl/video_timing_gen_pattern_gen.sv | 39 +++
 rtl/video_timing_gen.sv | 124 ++++++++++++
 tb/tb_video_timing_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared definitions for the video timing generator: pattern modes, 24-bit colours
// and standard timing presets.
package video_timing_gen_pkg;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'b00,
        PAT_GRID     = 2'b01,
        PAT_GRADIENT = 2'b10,
        PAT_SOLID    = 2'b11
    } pattern_e;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hs_pol;
        bit vs_pol;
    } timing_t;

    localparam timing_t TIMING_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    localparam timing_t TIMING_1280X720_60 = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};

    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] YELLOW  = 24'hFFFF00;
    localparam logic [23:0] CYAN    = 24'h00FFFF;
    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] BLUE    = 24'h0000FF;
    localparam logic [23:0] BLACK   = 24'h000000;

    // Colour-bar order, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_timing_gen_pattern_gen.sv
// Combinational test-pattern source: active-area coordinates and mode in, RGB out.
module video_timing_gen_pattern_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640
)(
    input  logic [11:0] x_i,
    input  logic [7:0]  y_i,
    input  logic [1:0]  mode_i,
    input  logic [23:0] solid_rgb_i,
    output logic [23:0] rgb_o
);
    localparam int BAR_W = H_ACTIVE / 8;

    logic [6:0]  past_edge;
    logic [2:0]  bar_idx;
    logic [7:0]  grad_b;

    // Bar index is the number of bar boundaries already passed, avoiding a divider.
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
            assign past_edge[gi-1] = (x_i >= 12'(gi * BAR_W));
        end
    endgenerate

    assign bar_idx = 3'($countones(past_edge));
    assign grad_b  = x_i[7:0] + y_i;

    always_comb begin
        rgb_o = BLACK;
        case (mode_i)
            PAT_BARS:     rgb_o = bar_colour(bar_idx);
            PAT_GRID:     rgb_o = (x_i[4:0] == 5'd0 || y_i[4:0] == 5'd0) ? WHITE : BLACK;
            PAT_GRADIENT: rgb_o = {x_i[7:0], y_i, grad_b};
            default:      rgb_o = solid_rgb_i;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-clock timing generator: h/v counters, sync decode, per-frame mode latch and
// one aligned output register stage feeding the TMDS lanes.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = TIMING_640X480_60.h_active,
    parameter int H_FP     = TIMING_640X480_60.h_fp,
    parameter int H_SYNC   = TIMING_640X480_60.h_sync,
    parameter int H_BP     = TIMING_640X480_60.h_bp,
    parameter int V_ACTIVE = TIMING_640X480_60.v_active,
    parameter int V_FP     = TIMING_640X480_60.v_fp,
    parameter int V_SYNC   = TIMING_640X480_60.v_sync,
    parameter int V_BP     = TIMING_640X480_60.v_bp,
    parameter bit HS_POL   = TIMING_640X480_60.hs_pol,
    parameter bit VS_POL   = TIMING_640X480_60.vs_pol
)(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  pattern_sel_i,
    input  logic [23:0] solid_rgb_i,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic [7:0]  red_o,
    output logic [7:0]  green_o,
    output logic [7:0]  blue_o,
    output logic        frame_start_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [23:0] solid_q, solid_d;
    logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic [23:0] rgb_q, rgb_d, pattern_rgb;
    logic        frame_origin, active, hs_on, vs_on;

    assign frame_origin = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
    assign active       = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
    assign hs_on        = (hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END);
    assign vs_on        = (vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END);

    // The latch is transparent at the origin so pixel (0,0) already uses the new frame's mode.
    assign mode_d  = frame_origin ? pattern_sel_i : mode_q;
    assign solid_d = frame_origin ? solid_rgb_i : solid_q;

    video_timing_gen_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_gen (
        .x_i         (hcnt_q),
        .y_i         (vcnt_q[7:0]),
        .mode_i      (mode_d),
        .solid_rgb_i (solid_d),
        .rgb_o       (pattern_rgb)
    );

    always_comb begin
        hcnt_d = (hcnt_q == H_LAST) ? 12'd0 : hcnt_q + 12'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            vcnt_d = (vcnt_q == V_LAST) ? 12'd0 : vcnt_q + 12'd1;
        end
        de_d          = active;
        hsync_d       = hs_on ? HS_POL : ~HS_POL;
        vsync_d       = vs_on ? VS_POL : ~VS_POL;
        x_d           = active ? hcnt_q : 12'd0;
        y_d           = active ? vcnt_q : 12'd0;
        rgb_d         = active ? pattern_rgb : 24'd0;
        frame_start_d = frame_origin;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcnt_q        <= 12'd0;
            vcnt_q        <= 12'd0;
            mode_q        <= PAT_BARS;
            solid_q       <= 24'd0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            x_q           <= 12'd0;
            y_q           <= 12'd0;
            rgb_q         <= 24'd0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            mode_q        <= mode_d;
            solid_q       <= solid_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            x_q           <= x_d;
            y_q           <= y_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign de_o          = de_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign red_o         = rgb_q[23:16];
    assign green_o       = rgb_q[15:8];
    assign blue_o        = rgb_q[7:0];
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: a small-timing instance (14 x 7) and a default 640x480 instance.
`timescale 1ns/1ps
module tb_video_timing_gen;

    typedef struct {
        int          cyc;
        string       tag;
        logic [51:0] vec;   // {de, hsync, vsync, frame_start, x, y, rgb}
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ns, rst_nb;
    logic [1:0]  sel_s, sel_b;
    logic [23:0] solid_s, solid_b;

    logic        s_de, s_hs, s_vs, s_fs, b_de, b_hs, b_vs, b_fs;
    logic [11:0] s_x, s_y, b_x, b_y;
    logic [7:0]  s_r, s_g, s_b, b_r, b_g, b_b;
    logic [51:0] obs_s, obs_b;

    int n_s = 0;
    int n_b = 0;
    int checks = 0;
    int errors = 0;

    exp_t q_s[$];
    exp_t q_b[$];
    exp_t e_s, e_b, e_end;

    logic [23:0] bars_tbl [8];

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b0), .VS_POL (1'b0)
    ) dut_s (
        .clk_i (clk), .rst_ni (rst_ns), .pattern_sel_i (sel_s), .solid_rgb_i (solid_s),
        .de_o (s_de), .hsync_o (s_hs), .vsync_o (s_vs), .x_o (s_x), .y_o (s_y),
        .red_o (s_r), .green_o (s_g), .blue_o (s_b), .frame_start_o (s_fs)
    );

    video_timing_gen dut_b (
        .clk_i (clk), .rst_ni (rst_nb), .pattern_sel_i (sel_b), .solid_rgb_i (solid_b),
        .de_o (b_de), .hsync_o (b_hs), .vsync_o (b_vs), .x_o (b_x), .y_o (b_y),
        .red_o (b_r), .green_o (b_g), .blue_o (b_b), .frame_start_o (b_fs)
    );

    assign obs_s = {s_de, s_hs, s_vs, s_fs, s_x, s_y, s_r, s_g, s_b};
    assign obs_b = {b_de, b_hs, b_vs, b_fs, b_x, b_y, b_r, b_g, b_b};

    // Edges since reset release; outputs seen at cycle n belong to counter position n-1.
    always @(posedge clk or negedge rst_ns) begin
        if (!rst_ns) n_s <= 0;
        else         n_s <= n_s + 1;
    end
    always @(posedge clk or negedge rst_nb) begin
        if (!rst_nb) n_b <= 0;
        else         n_b <= n_b + 1;
    end

    task automatic push(input bit big, input int cyc, input string tag,
                        input logic de, input logic hs, input logic vs, input logic fs,
                        input int x, input int y, input logic [23:0] rgb);
        exp_t e;
        e.cyc = cyc;
        e.tag = tag;
        e.vec = {de, hs, vs, fs, 12'(x), 12'(y), rgb};
        if (big) q_b.push_back(e);
        else     q_s.push_back(e);
    endtask

    task automatic check(input exp_t e, input int n, input logic [51:0] got);
        checks++;
        if (e.cyc != n) begin
            errors++;
            $display("FAIL %s: compared at cycle %0d, required cycle %0d", e.tag, n, e.cyc);
        end else if (got !== e.vec) begin
            errors++;
            $display("FAIL %s cyc=%0d: got de/hs/vs/fs=%b x=%0d y=%0d rgb=%h, required de/hs/vs/fs=%b x=%0d y=%0d rgb=%h",
                     e.tag, n, got[51:48], got[47:36], got[35:24], got[23:0],
                     e.vec[51:48], e.vec[47:36], e.vec[35:24], e.vec[23:0]);
        end else begin
            $display("check %s cyc=%0d ok: de/hs/vs/fs=%b x=%0d y=%0d rgb=%h",
                     e.tag, n, got[51:48], got[47:36], got[35:24], got[23:0]);
        end
    endtask

    always @(negedge clk) begin
        while (q_s.size() > 0 && q_s[0].cyc <= n_s) begin
            e_s = q_s.pop_front();
            check(e_s, n_s, obs_s);
        end
    end

    always @(negedge clk) begin
        while (q_b.size() > 0 && q_b[0].cyc <= n_b) begin
            e_b = q_b.pop_front();
            check(e_b, n_b, obs_b);
        end
    end

    task automatic wait_n(input bit big, input int target);
        int k;
        k = 0;
        while ((big ? n_b : n_s) < target && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if ((big ? n_b : n_s) < target) begin
            checks++;
            errors++;
            $display("FAIL wait_cycle: reached %0d, required %0d", big ? n_b : n_s, target);
        end
    endtask

    initial begin
        bars_tbl[0] = 24'hFFFFFF; bars_tbl[1] = 24'hFFFF00;
        bars_tbl[2] = 24'h00FFFF; bars_tbl[3] = 24'h00FF00;
        bars_tbl[4] = 24'hFF00FF; bars_tbl[5] = 24'hFF0000;
        bars_tbl[6] = 24'h0000FF; bars_tbl[7] = 24'h000000;

        rst_ns = 1'b0; rst_nb = 1'b0;
        sel_s  = 2'b00; solid_s = 24'h123456;
        sel_b  = 2'b10; solid_b = 24'h000000;

        // Small instance, frame 1: reset, bars, line and frame timing.
        push(0, 0,  "reset",       0, 1, 1, 0, 0, 0, 24'h0);
        for (int k = 0; k < 8; k++)
            push(0, k + 1, "bars", 1, 1, 1, (k == 0), k, 0, bars_tbl[k]);
        push(0, 9,  "h_fp",        0, 1, 1, 0, 0, 0, 24'h0);
        push(0, 10, "hs_pre",      0, 1, 1, 0, 0, 0, 24'h0);
        push(0, 11, "hs_start",    0, 0, 1, 0, 0, 0, 24'h0);
        push(0, 12, "hs_last",     0, 0, 1, 0, 0, 0, 24'h0);
        push(0, 13, "hs_end",      0, 1, 1, 0, 0, 0, 24'h0);
        push(0, 15, "line1",       1, 1, 1, 0, 0, 1, 24'hFFFFFF);
        push(0, 50, "last_active", 1, 1, 1, 0, 7, 3, 24'h000000);
        push(0, 57, "v_fp",        0, 1, 1, 0, 0, 0, 24'h0);
        push(0, 70, "vs_pre",      0, 1, 1, 0, 0, 0, 24'h0);
        push(0, 71, "vs_start",    0, 1, 0, 0, 0, 0, 24'h0);
        push(0, 81, "vs_hs",       0, 0, 0, 0, 0, 0, 24'h0);
        push(0, 84, "vs_last",     0, 1, 0, 0, 0, 0, 24'h0);
        push(0, 85, "vs_end",      0, 1, 1, 0, 0, 0, 24'h0);
        push(0, 99, "frame2",      1, 1, 1, 1, 0, 0, 24'hFFFFFF);
        // Mode latch: switch to solid mid-frame 2, then to grid mid-frame 3.
        push(0, 130, "bars_hold",   1, 1, 1, 0, 3, 2, 24'h00FF00);
        push(0, 148, "bars_end",    1, 1, 1, 0, 7, 3, 24'h000000);
        push(0, 197, "solid_f3",    1, 1, 1, 1, 0, 0, 24'h123456);
        push(0, 244, "solid_latch", 1, 1, 1, 0, 5, 3, 24'h123456);
        push(0, 295, "grid_origin", 1, 1, 1, 1, 0, 0, 24'hFFFFFF);
        push(0, 298, "grid_row0",   1, 1, 1, 0, 3, 0, 24'hFFFFFF);
        push(0, 309, "grid_col0",   1, 1, 1, 0, 0, 1, 24'hFFFFFF);
        push(0, 328, "grid_black",  1, 1, 1, 0, 5, 2, 24'h000000);

        // Default 640x480 instance, gradient.
        push(1, 0,    "b_reset",    0, 1, 1, 0, 0,   0,  24'h0);
        push(1, 1,    "b_origin",   1, 1, 1, 1, 0,   0,  24'h000000);
        push(1, 656,  "b_hs_pre",   0, 1, 1, 0, 0,   0,  24'h0);
        push(1, 657,  "b_hs_start", 0, 0, 1, 0, 0,   0,  24'h0);
        push(1, 752,  "b_hs_last",  0, 0, 1, 0, 0,   0,  24'h0);
        push(1, 753,  "b_hs_end",   0, 1, 1, 0, 0,   0,  24'h0);
        push(1, 800,  "b_line_end", 0, 1, 1, 0, 0,   0,  24'h0);
        push(1, 801,  "b_line1",    1, 1, 1, 0, 0,   1,  24'h000101);
        push(1, 8301, "b_gradient", 1, 1, 1, 0, 300, 10, 24'h2C0A36);

        repeat (3) @(negedge clk);
        rst_ns = 1'b1;
        rst_nb = 1'b1;

        wait_n(0, 110);
        sel_s = 2'b11;
        wait_n(0, 210);
        solid_s = 24'h654321;
        sel_s   = 2'b01;

        // Asynchronous reset in the middle of an active pixel run.
        wait_n(0, 395);
        @(posedge clk);
        #2;
        push(0, 0, "rst_async", 0, 1, 1, 0, 0, 0, 24'h0);
        rst_ns = 1'b0;
        repeat (2) @(negedge clk);
        push(0, 1,  "restart",      1, 1, 1, 1, 0, 0, 24'hFFFFFF);
        push(0, 2,  "restart_x1",   1, 1, 1, 0, 1, 0, 24'hFFFFFF);
        push(0, 18, "restart_grid", 1, 1, 1, 0, 3, 1, 24'h000000);
        rst_ns = 1'b1;

        wait_n(1, 8305);
        @(negedge clk);
        while (q_s.size() > 0) begin
            e_end = q_s.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never reached, small counter at %0d, required cycle %0d", e_end.tag, n_s, e_end.cyc);
        end
        while (q_b.size() > 0) begin
            e_end = q_b.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never reached, large counter at %0d, required cycle %0d", e_end.tag, n_b, e_end.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
